// File: rtl/lpddr2_frame_reader_if.sv
// Avalon-MM read channel plus the outgoing pixel stream of the LPDDR2 frame reader.
// The master modport is the reader side; slave is the controller/downstream side.
interface lpddr2_frame_reader_if #(
  parameter int ADDR_W = 27
);
  logic              avl_waitrequest_n;
  logic [ADDR_W-1:0] avl_address;
  logic              avl_read;
  logic              avl_burstbegin;
  logic              avl_readdatavalid;
  logic [31:0]       avl_readdata;
  logic [23:0]       pix_data;
  logic              pix_valid;
  logic              pix_ready;

  modport master (
    input  avl_waitrequest_n, avl_readdatavalid, avl_readdata, pix_ready,
    output avl_address, avl_read, avl_burstbegin, pix_data, pix_valid
  );

  modport slave (
    output avl_waitrequest_n, avl_readdatavalid, avl_readdata, pix_ready,
    input  avl_address, avl_read, avl_burstbegin, pix_data, pix_valid
  );
endinterface

// File: rtl/lpddr2_frame_reader.sv
// Fetches one frame from LPDDR2 avl_0 into a FWFT FIFO and streams it out as pixels.
// Optional LPDDR2_FRAME_READER_UNDERFLOW_CNT_EN adds underflow_cnt / sticky_underflow.
module lpddr2_frame_reader #(
  parameter int ADDR_W         = 27,
  parameter int BASE_ADDR      = 0,
  parameter int WORDS_PER_LINE = 1920,
  parameter int LINES          = 1080,
  parameter int FIFO_DEPTH     = 512,
  parameter int CNT_W          = 22
) (
  input  logic                         iCLK,
  input  logic                         iRST_n,
  input  logic                         frame_start,
  input  logic                         local_init_done,
  lpddr2_frame_reader_if.master        bus,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         underflow
`ifdef LPDDR2_FRAME_READER_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]                  underflow_cnt,
  output logic [0:0]                   sticky_underflow
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [CNT_W-1:0]  TOTAL   = CNT_W'(WORDS_PER_LINE * LINES);
  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [PW:0]       DEPTH_X = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_INIT, FETCH, DRAIN} state_t;
  state_t state;

  logic [CNT_W-1:0] issue_cnt, pop_cnt, issue_nxt;
  logic [PW-1:0]    outstanding, fifo_count, out_nxt, cnt_nxt;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [23:0]      mem [FIFO_DEPTH];
  logic             accept, rdv, wr, pop, empty, full, credit;
  logic             unused_rd_hi;

  assign accept    = bus.avl_read & bus.avl_waitrequest_n;
  // Returns with nothing outstanding are stale leftovers and are dropped.
  assign rdv       = bus.avl_readdatavalid & (outstanding != '0);
  assign empty     = (fifo_count == '0);
  assign full      = (fifo_count == PW'(FIFO_DEPTH));
  assign wr        = rdv & ~full;
  assign pop       = ~empty & bus.pix_ready;
  assign out_nxt   = outstanding + PW'(accept) - PW'(rdv);
  assign cnt_nxt   = fifo_count + PW'(wr) - PW'(pop);
  // Credit judged on next-cycle occupancy so the registered avl_read never overcommits.
  assign credit    = ({1'b0, cnt_nxt} + {1'b0, out_nxt}) < DEPTH_X;
  assign issue_nxt = issue_cnt + CNT_W'(accept);

  assign bus.pix_valid = ~empty;
  assign bus.pix_data  = empty ? 24'd0 : mem[rd_ptr];
  assign underflow     = busy & (state != WAIT_INIT) & bus.pix_ready & empty;
  assign unused_rd_hi  = ^bus.avl_readdata[31:24];

  always_ff @(posedge iCLK) begin
    if (wr) mem[wr_ptr] <= bus.avl_readdata[23:0];
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      outstanding <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      fifo_count  <= cnt_nxt;
      outstanding <= out_nxt;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state              <= IDLE;
      busy               <= 1'b0;
      frame_done         <= 1'b0;
      issue_cnt          <= '0;
      pop_cnt            <= '0;
      bus.avl_read       <= 1'b0;
      bus.avl_burstbegin <= 1'b0;
      bus.avl_address    <= BASE;
    end else begin
      frame_done <= 1'b0;
      if (busy && pop) pop_cnt <= pop_cnt + CNT_W'(1);
      if (accept) begin
        issue_cnt       <= issue_nxt;
        bus.avl_address <= bus.avl_address + ADDR_W'(1);
      end
      case (state)
        IDLE: if (frame_start) begin
          state           <= WAIT_INIT;
          busy            <= 1'b1;
          issue_cnt       <= '0;
          pop_cnt         <= '0;
          bus.avl_address <= BASE;
        end
        WAIT_INIT: if (local_init_done) state <= FETCH;
        FETCH: begin
          if (accept && issue_nxt == TOTAL) begin
            bus.avl_read       <= 1'b0;
            bus.avl_burstbegin <= 1'b0;
            state              <= DRAIN;
          end else begin
            // Every request is a single-beat burst, so burstbegin tracks avl_read.
            bus.avl_read       <= (bus.avl_read & ~accept) | credit;
            bus.avl_burstbegin <= (bus.avl_read & ~accept) | credit;
          end
        end
        DRAIN: if (pop && (pop_cnt + CNT_W'(1)) == TOTAL) begin
          state      <= IDLE;
          busy       <= 1'b0;
          frame_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LPDDR2_FRAME_READER_UNDERFLOW_CNT_EN
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      underflow_cnt    <= '0;
      sticky_underflow <= 1'b0;
    end else begin
      if (state == IDLE && frame_start)         underflow_cnt <= '0;
      else if (underflow && underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 16'd1;
      if (underflow) sticky_underflow <= 1'b1;
    end
  end
`endif

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge iCLK) disable iff (!iRST_n) !(rdv && full));
`endif
endmodule

// File: tb/tb_lpddr2_frame_reader.sv
// Scoreboard bench: expected pixels queued at frame start, checked as the stream pops;
// a latency-programmable memory model answers reads with their address as data.
module tb_lpddr2_frame_reader;
  localparam int BASE = 'h100;
  localparam int NPIX = 8;

  logic iCLK = 1'b0, iRST_n, frame_start, local_init_done;
  logic busy, frame_done, underflow;
`ifdef LPDDR2_FRAME_READER_UNDERFLOW_CNT_EN
  logic [15:0] underflow_cnt;
  logic [0:0]  sticky_underflow;
`endif

  lpddr2_frame_reader_if #(.ADDR_W(27)) bus ();

  lpddr2_frame_reader #(
    .ADDR_W(27), .BASE_ADDR(BASE), .WORDS_PER_LINE(4), .LINES(2),
    .FIFO_DEPTH(4), .CNT_W(22)
  ) dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .frame_start(frame_start),
    .local_init_done(local_init_done), .bus(bus.master),
    .busy(busy), .frame_done(frame_done), .underflow(underflow)
`ifdef LPDDR2_FRAME_READER_UNDERFLOW_CNT_EN
    , .underflow_cnt(underflow_cnt), .sticky_underflow(sticky_underflow)
`endif
  );

  always #5 iCLK = ~iCLK;

  int total = 0, bad = 0;
  int lat = 2, edge_n = 0;
  int n_acc, n_pix, n_done, n_uf, n_ufexp, n_rd;
  logic [26:0] exp_addr;
  logic [26:0] addr_q[$];
  int          due_q[$];
  logic [23:0] exp_pix[$];
  logic        prev_busy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge iCLK) edge_n++;

  // Memory model, acceptance checker and output scoreboard, all off the active edge.
  always @(negedge iCLK) begin
    if (!iRST_n) begin
      addr_q.delete();
      due_q.delete();
      bus.avl_readdatavalid = 1'b0;
      bus.avl_readdata      = '0;
      prev_busy             = 1'b0;
    end else begin
      if (due_q.size() > 0 && due_q[0] == edge_n + 1) begin
        logic [26:0] a;
        a = addr_q.pop_front();
        void'(due_q.pop_front());
        bus.avl_readdatavalid = 1'b1;
        bus.avl_readdata      = {8'hA5, a[23:0]};
      end else begin
        bus.avl_readdatavalid = 1'b0;
        bus.avl_readdata      = $urandom;
      end
      if (bus.avl_read) n_rd++;
      if (bus.avl_read && bus.avl_waitrequest_n) begin
        chk("addr", bus.avl_address, exp_addr);
        chk("burstbegin", bus.avl_burstbegin, 1);
        exp_addr++;
        n_acc++;
        addr_q.push_back(bus.avl_address);
        due_q.push_back(edge_n + 1 + lat);
      end
      if (bus.pix_valid && bus.pix_ready) begin
        if (exp_pix.size() == 0) chk("extra_pix", exp_pix.size(), 1);
        else chk("pix", bus.pix_data, exp_pix.pop_front());
        n_pix++;
      end
      if (frame_done) n_done++;
      if (underflow) n_uf++;
      if (busy && bus.pix_ready && !bus.pix_valid && prev_busy) n_ufexp++;
      prev_busy = busy;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge iCLK);
    #1;
  endtask

  task automatic clr();
    n_acc = 0; n_pix = 0; n_done = 0; n_uf = 0; n_ufexp = 0; n_rd = 0;
  endtask

  task automatic start(input bit expect_run);
    @(posedge iCLK); #1;
    if (expect_run) begin
      exp_addr = 27'(BASE);
      for (int i = 0; i < NPIX; i++) exp_pix.push_back(24'(BASE + i));
    end
    frame_start = 1'b1;
    cyc(1);
    frame_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin @(negedge iCLK); k++; end
    chk("idle_timeout", busy, 0);
    cyc(2);
  endtask

  task automatic wait_acc(input int n, input int budget);
    int k = 0;
    while (n_acc < n && k < budget) begin @(negedge iCLK); k++; end
    chk("acc_timeout", (n_acc >= n), 1);
  endtask

  task automatic rst_chk(input string p);
    chk({p, "_read"},  bus.avl_read, 0);
    chk({p, "_bb"},    bus.avl_burstbegin, 0);
    chk({p, "_addr"},  bus.avl_address, BASE);
    chk({p, "_pv"},    bus.pix_valid, 0);
    chk({p, "_pd"},    bus.pix_data, 0);
    chk({p, "_busy"},  busy, 0);
    chk({p, "_done"},  frame_done, 0);
    chk({p, "_uf"},    underflow, 0);
  endtask

  task automatic frame_ok(input string p);
    chk({p, "_acc"},  n_acc, NPIX);
    chk({p, "_pix"},  n_pix, NPIX);
    chk({p, "_done"}, n_done, 1);
    chk({p, "_left"}, exp_pix.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1);
  end

  initial begin
    iRST_n = 1'b0; frame_start = 1'b0; local_init_done = 1'b1;
    bus.avl_waitrequest_n = 1'b1; bus.pix_ready = 1'b1;
    exp_addr = 27'(BASE);
    clr();
    cyc(3);
    rst_chk("rst");
    iRST_n = 1'b1;
    cyc(2);

    // Basic frame, data returned 2 cycles after acceptance.
    clr(); start(1); wait_idle(200); frame_ok("t1");
    chk("t1_busy", busy, 0);

    // Backpressure: credit stops issue at FIFO_DEPTH.
    clr(); bus.pix_ready = 1'b0; start(1); cyc(30);
    chk("t2_acc4", n_acc, 4);
    chk("t2_read0", bus.avl_read, 0);
    chk("t2_pv", bus.pix_valid, 1);
    bus.pix_ready = 1'b1; wait_idle(200); frame_ok("t2");

    // Waitrequest stall mid-frame.
    clr(); start(1); wait_acc(3, 100);
    @(posedge iCLK); #1 bus.avl_waitrequest_n = 1'b0;
    begin
      logic [26:0] a0;
      for (int k = 0; k < 5; k++) begin
        @(negedge iCLK);
        if (k == 0) a0 = bus.avl_address;
        else begin
          chk("t3_addr_hold", bus.avl_address, a0);
          chk("t3_read_hold", bus.avl_read, 1);
          chk("t3_bb_hold", bus.avl_burstbegin, 1);
        end
      end
    end
    @(posedge iCLK); #1 bus.avl_waitrequest_n = 1'b1;
    wait_idle(200); frame_ok("t3");

    // Init not done: no reads; a second start while busy is ignored.
    clr(); local_init_done = 1'b0; start(1); cyc(10);
    start(0); cyc(8);
    chk("t4_noread", n_rd, 0);
    chk("t4_busy", busy, 1);
    local_init_done = 1'b1;
    wait_idle(200); cyc(5); frame_ok("t4");
    chk("t4_idle", busy, 0);

    // Long latency: underflow every empty cycle past WAIT_INIT.
    clr(); lat = 10; start(1); wait_idle(400); frame_ok("t5");
    chk("t5_uf_seen", (n_uf > 0), 1);
    chk("t5_uf_count", n_uf, n_ufexp);
`ifdef LPDDR2_FRAME_READER_UNDERFLOW_CNT_EN
    chk("t5_uf_cnt", underflow_cnt, n_uf);
    chk("t5_sticky", sticky_underflow, 1);
`endif
    lat = 2;

    // Asynchronous reset mid-frame, then a clean restart from BASE.
    clr(); start(1); wait_acc(3, 100);
    @(negedge iCLK); #2 iRST_n = 1'b0;
    #1 rst_chk("arst");
    exp_pix.delete();
    cyc(2); iRST_n = 1'b1; cyc(2);
    clr(); start(1); wait_idle(200); frame_ok("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lpddr2_frame_reader.md
Name: lpddr2_frame_reader

Overview:
- Avalon-MM read master that fetches one video frame from LPDDR2 (port avl_0 of the LPDDR2 controller) and buffers it in an internal single-clock FIFO.
- Presents the frame as a valid/ready pixel stream.
- Sits between the LPDDR2 controller and the video-output CDC FIFO that feeds the ADV7513 path.
- Runs on afi_half_clk and replaces the RW test master on avl_0 in TX playback mode.

Parameters:
- ADDR_W, 27, Avalon word-address width
- BASE_ADDR, 0, word address of pixel (0,0)
- WORDS_PER_LINE, 1920, 32-bit words (pixels) per line
- LINES, 1080, lines per frame
- FIFO_DEPTH, 512, internal FIFO entries, power of two, >= 4
- CNT_W, 22, frame word counter width; must hold WORDS_PER_LINE*LINES

Ports:
- iCLK  in  1  afi_half_clk
- iRST_n  in  1  asynchronous active-low reset
- frame_start  in  1  single-cycle pulse; begin fetching one frame
- local_init_done  in  1  LPDDR2 init and calibration complete
- avl_waitrequest_n  in  1  controller ready (avl_ready_0)
- avl_address  out  ADDR_W  read word address
- avl_read  out  1  read request
- avl_burstbegin  out  1  high with every new request (burstcount fixed 1 at top level)
- avl_readdatavalid  in  1  read data valid
- avl_readdata  in  32  read data; [23:0] = RGB888
- pix_data  out  24  pixel to downstream
- pix_valid  out  1  pix_data valid
- pix_ready  in  1  downstream accepts
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse on last pixel pop
- underflow  out  1  one-cycle pulse, see Behaviour

Behaviour:
- Reset values: avl_read=0, avl_burstbegin=0, avl_address=BASE_ADDR, pix_valid=0, pix_data=0, busy=0, frame_done=0, underflow=0. FIFO is empty and all counters are 0.
- FSM states: IDLE, WAIT_INIT, FETCH, DRAIN.
  - IDLE: on frame_start, go to WAIT_INIT, busy=1, issue counter=0, pop counter=0.
  - WAIT_INIT: when local_init_done=1, go to FETCH.
  - FETCH: issue reads. When the issue counter reaches WORDS_PER_LINE*LINES, deassert avl_read in the same cycle as the final acceptance and go to DRAIN.
  - DRAIN: when the pop counter reaches the total, go to IDLE, busy=0.
- frame_start while busy=1 is ignored.
- A request is accepted when avl_read=1 and avl_waitrequest_n=1.
- While avl_waitrequest_n=0, avl_read and avl_address are held stable.
- avl_address = BASE_ADDR + issue count. The address advances by 1 per acceptance and is linear across lines (no line stride). Address arithmetic wraps at 2^ADDR_W.
- avl_burstbegin = 1 whenever avl_read=1 and the request is new, i.e. the first cycle after reset or after the previous acceptance. It stays asserted while the request is held.
- Credit rule: avl_read may assert only if fifo_count + outstanding < FIFO_DEPTH.
  - outstanding increments on acceptance and decrements on avl_readdatavalid. Simultaneous events net to zero.
  - The FIFO therefore never overflows. A readdatavalid with the FIFO full is a design error; flag it with a sim-only assertion.
- FIFO write: avl_readdata[23:0] is written on avl_readdatavalid. Bits [31:24] are discarded.
- FIFO read is first-word-fall-through:
  - pix_valid = FIFO not empty; pix_data = head entry.
  - A pop occurs when pix_valid & pix_ready.
  - Write and pop in the same cycle are legal at any fill level, including empty (the write lands, no pop) and full (no write is possible per the credit rule).
- Pixel latency: a word returned on readdatavalid at cycle N is visible on pix_data at cycle N+1.
- frame_done pulses the cycle after the final pop.
- underflow pulses for every cycle in which busy=1, state≠WAIT_INIT, pix_ready=1 and the FIFO is empty.
- Reset mid-operation:
  - All state is cleared asynchronously.
  - iRST_n must share the controller's mp_cmd reset, so that no stale readdatavalid arrives afterwards.
  - Any readdatavalid while outstanding=0 is dropped.

Optional Feature:
- Macro: LPDDR2_FRAME_READER_UNDERFLOW_CNT_EN.
- Defined:
  - Adds output port underflow_cnt [15:0]: a saturating count of underflow pulses, cleared on reset and on frame_start acceptance, held at 16'hFFFF when saturated.
  - Adds output sticky_underflow [0:0], set by any underflow and cleared only by reset.
- Undefined: neither port exists and no counter logic is synthesised.

Test Plan:
- WORDS_PER_LINE=4, LINES=2, FIFO_DEPTH=4, BASE_ADDR=0x100, memory model returns addr as data with 2-cycle latency, pix_ready=1 -> 8 requests to 0x100..0x107; pix_data 0x000100..0x000107 in order; frame_done single pulse; busy low after.
- Same setup, pix_ready=0 -> exactly 4 reads accepted, then avl_read=0; releasing pix_ready resumes until 8 total.
- avl_waitrequest_n low for 5 cycles mid-frame -> avl_address/avl_read stable; avl_burstbegin held high; no duplicate or skipped address.
- frame_start with local_init_done=0 for 20 cycles -> no avl_read until init_done rises; second frame_start while busy -> ignored (still 8 pixels only).
- Memory latency 10 cycles with pix_ready=1 -> underflow pulses while FIFO is empty; with LPDDR2_FRAME_READER_UNDERFLOW_CNT_EN, underflow_cnt equals the counted pulses.
- iRST_n asserted after 3 accepts -> all outputs at reset values asynchronously; next frame_start restarts at 0x100.
